// File: rtl/sp_data_ctrl_gen_pkg.sv
// Shared types and mode codes for the printhead SP-data controller.
// Modes pick what each channel drives while a print cycle is shifting.
package sp_data_pkg;

  localparam logic [7:0] MODE_ZERO  = 8'h00;
  localparam logic [7:0] MODE_ONES  = 8'h02;
  localparam logic [7:0] MODE_PRINT = 8'h03;
  localparam logic [7:0] MODE_WALK  = 8'h04;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

endpackage

// File: rtl/sp_data_ctrl_gen_if.sv
// Host-side command/status bundle of the SP-data controller.
// master = host register side, slave = controller.
interface sp_data_ctrl_gen_if #(
  parameter int NUM_CH = 16,
  parameter int CMD_W  = 16,
  parameter int ADDR_W = 8
);

  localparam int CW = $clog2(CMD_W);

  logic              sp_start;
  logic              sp_req;
  logic              sp_abort;
  logic [7:0]        data_type;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CMD_W-1:0]  wr_data;
  logic [NUM_CH-1:0] sp_data;
  logic              sp_busy;
  logic              sp_done;
  logic [CW-1:0]     bit_idx;

  modport master (
    output sp_start, sp_req, sp_abort, data_type,
    output wr_en, wr_addr, wr_data,
    input  sp_data, sp_busy, sp_done, bit_idx
  );

  modport slave (
    input  sp_start, sp_req, sp_abort, data_type,
    input  wr_en, wr_addr, wr_data,
    output sp_data, sp_busy, sp_done, bit_idx
  );

endinterface

// File: rtl/sp_chan_shift.sv
// One serial channel: parallel load of a command word, MSB-first shift.
// load wins over shift when both are asserted.
module sp_chan_shift #(
  parameter int CMD_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             shift,
  input  logic [CMD_W-1:0] din,
  output logic             msb
);

  logic [CMD_W-1:0] sr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[CMD_W-2:0], 1'b0};
    end
  end

  assign msb = sr[CMD_W-1];

endmodule

// File: rtl/sp_data_ctrl_gen.sv
// SP-data controller: shadow command bank, print-cycle FSM and
// per-channel serial output muxing for the printhead driver pins.
module sp_data_ctrl_gen
  import sp_data_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int CMD_W  = 16,
  parameter int ADDR_W = 8
) (
  input  logic clk,
  input  logic rstn,
  sp_data_ctrl_gen_if.slave bus
);

  localparam int CW = $clog2(CMD_W);
  localparam logic [CW-1:0] LAST = CW'(CMD_W - 1);

  state_t            state;
  state_t            state_nx;
  logic [CW-1:0]     cnt;
  logic [7:0]        mode;
  logic              done_q;
  logic              load;
  logic              adv;
  logic              fin;
  logic              clr;
  logic [NUM_CH-1:0] msb;
  logic [NUM_CH-1:0] data;
  logic [CMD_W-1:0]  shadow [NUM_CH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // abort beats start beats req; abort in IDLE also swallows a start
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    adv      = 1'b0;
    fin      = 1'b0;
    clr      = 1'b0;
    if (bus.sp_abort) begin
      state_nx = ST_IDLE;
      clr      = 1'b1;
    end else if (bus.sp_start) begin
      state_nx = ST_SHIFT;
      load     = 1'b1;
      clr      = 1'b1;
    end else if (state == ST_SHIFT && bus.sp_req) begin
      if (cnt == LAST) begin
        state_nx = ST_IDLE;
        fin      = 1'b1;
        clr      = 1'b1;
      end else begin
        adv = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      mode   <= MODE_ZERO;
      done_q <= 1'b0;
    end else begin
      if (clr)      cnt <= '0;
      else if (adv) cnt <= cnt + 1'b1;
      if (load) mode <= bus.data_type;
      done_q <= fin;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else if (bus.wr_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.wr_addr == ADDR_W'(i)) shadow[i] <= bus.wr_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sp_chan_shift #(.CMD_W(CMD_W)) u_ch (
      .clk   (clk),
      .rstn  (rstn),
      .load  (load),
      .shift (adv),
      .din   (shadow[g]),
      .msb   (msb[g])
    );
  end

  always_comb begin
    data = '0;
    if (state == ST_SHIFT) begin
      for (int c = 0; c < NUM_CH; c++) begin
        unique case (mode)
          MODE_PRINT: data[c] = msb[c];
          MODE_ONES:  data[c] = 1'b1;
          MODE_WALK:  data[c] = (CW'(c % CMD_W) == cnt);
          default:    data[c] = 1'b0;
        endcase
      end
    end
  end

  assign bus.sp_data = data;
  assign bus.sp_busy = (state == ST_SHIFT);
  assign bus.sp_done = done_q;
  assign bus.bit_idx = cnt;

endmodule

// File: tb/tb_sp_data_ctrl_gen.sv
// Directed bench for sp_data_ctrl_gen.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_sp_data_ctrl_gen;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int passed = 0;
  int total  = 0;
  logic [15:0] a;
  logic [15:0] b;

  always #5 clk = ~clk;

  sp_data_ctrl_gen_if #(.NUM_CH(16), .CMD_W(16), .ADDR_W(8)) bus ();

  sp_data_ctrl_gen #(.NUM_CH(16), .CMD_W(16), .ADDR_W(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [15:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic start(input logic [7:0] m);
    bus.data_type = m;
    bus.sp_start  = 1'b1;
    step();
    bus.sp_start  = 1'b0;
  endtask

  task automatic req();
    bus.sp_req = 1'b1;
    step();
    bus.sp_req = 1'b0;
  endtask

  task automatic abort();
    bus.sp_abort = 1'b1;
    step();
    bus.sp_abort = 1'b0;
  endtask

  initial begin
    bus.sp_start  = 1'b0;
    bus.sp_req    = 1'b0;
    bus.sp_abort  = 1'b0;
    bus.data_type = 8'h00;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;

    // reset state
    #2 rstn = 1'b0;
    #1;
    chk("rst_data", bus.sp_data, 16'h0);
    chk("rst_busy", bus.sp_busy, 1'b0);
    chk("rst_done", bus.sp_done, 1'b0);
    chk("rst_idx", bus.bit_idx, 4'd0);
    step();
    @(negedge clk) rstn = 1'b1;
    step();

    // 1: print mode, full 16-bit cycle
    a = 16'hA5A5;
    b = 16'h8001;
    wr(8'd0, a);
    wr(8'd15, b);
    start(8'h03);
    for (int i = 0; i < 16; i++) begin
      chk("t1_data", bus.sp_data, {b[15-i], 14'b0, a[15-i]});
      chk("t1_idx", bus.bit_idx, i[3:0]);
      chk("t1_busy", bus.sp_busy, 1'b1);
      chk("t1_nodone", bus.sp_done, 1'b0);
      req();
    end
    chk("t1_done", bus.sp_done, 1'b1);
    chk("t1_busy_fall", bus.sp_busy, 1'b0);
    chk("t1_idle_data", bus.sp_data, 16'h0);
    chk("t1_idx0", bus.bit_idx, 4'd0);
    step();
    chk("t1_done_1cyc", bus.sp_done, 1'b0);

    // 2: all-ones mode, abort after 8 bits
    start(8'h02);
    for (int i = 0; i < 9; i++) begin
      chk("t2_data", bus.sp_data, 16'hFFFF);
      chk("t2_idx", bus.bit_idx, i[3:0]);
      chk("t2_nodone", bus.sp_done, 1'b0);
      if (i < 8) req();
    end
    abort();
    chk("t2_ab_data", bus.sp_data, 16'h0);
    chk("t2_ab_busy", bus.sp_busy, 1'b0);
    chk("t2_ab_done", bus.sp_done, 1'b0);
    chk("t2_ab_idx", bus.bit_idx, 4'd0);
    step();
    chk("t2_ab_done2", bus.sp_done, 1'b0);

    // 3: walking one
    start(8'h04);
    for (int n = 0; n < 16; n++) begin
      chk("t3_walk", bus.sp_data, 32'(1) << n);
      req();
    end
    chk("t3_done", bus.sp_done, 1'b1);

    // 4: writes and mode changes mid-cycle do not disturb it
    start(8'h03);
    repeat (5) req();
    chk("t4_idx5", bus.bit_idx, 4'd5);
    chk("t4_bit10", bus.sp_data, 16'h0001);
    bus.data_type = 8'h02;
    wr(8'd0, 16'hFFFF);
    chk("t4_hold_data", bus.sp_data, 16'h0001);
    chk("t4_hold_idx", bus.bit_idx, 4'd5);
    req();
    chk("t4_bit9_mode03", bus.sp_data, 16'h0000);
    start(8'h02);
    chk("t4_rs_idx", bus.bit_idx, 4'd0);
    chk("t4_rs_data", bus.sp_data, 16'hFFFF);
    chk("t4_rs_busy", bus.sp_busy, 1'b1);
    chk("t4_rs_nodone", bus.sp_done, 1'b0);
    abort();

    // 5: out-of-range write ignored
    wr(8'h10, 16'h1234);
    start(8'h03);
    for (int i = 0; i < 4; i++) begin
      chk("t5_data", bus.sp_data, {b[15-i], 14'b0, 1'b1});
      req();
    end
    chk("t5_idx4", bus.bit_idx, 4'd4);

    // 6: async reset mid-shift
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_data", bus.sp_data, 16'h0);
    chk("t6_rst_busy", bus.sp_busy, 1'b0);
    chk("t6_rst_done", bus.sp_done, 1'b0);
    chk("t6_rst_idx", bus.bit_idx, 4'd0);
    @(negedge clk) rstn = 1'b1;
    step();

    // start and write on one edge: snapshot is pre-write
    bus.wr_en   = 1'b1;
    bus.wr_addr = 8'd1;
    bus.wr_data = 16'hFFFF;
    start(8'h03);
    bus.wr_en   = 1'b0;
    chk("t6_zero_data", bus.sp_data, 16'h0);
    chk("t6_busy", bus.sp_busy, 1'b1);
    req();
    chk("t6_zero_data1", bus.sp_data, 16'h0);
    chk("t6_idx1", bus.bit_idx, 4'd1);

    // abort beats start on the same edge
    bus.sp_start = 1'b1;
    abort();
    bus.sp_start = 1'b0;
    chk("pri_busy", bus.sp_busy, 1'b0);
    chk("pri_idx", bus.bit_idx, 4'd0);

    // req in IDLE ignored
    req();
    chk("idle_req_idx", bus.bit_idx, 4'd0);
    chk("idle_req_busy", bus.sp_busy, 1'b0);

    // the write from the start edge is now visible
    start(8'h03);
    chk("late_wr", bus.sp_data, 16'h0002);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
